// File: rtl/vedic_pkg.sv
// Shared constants and elaboration helpers for the pipelined Vedic multiplier.
package vedic_pkg;

    localparam int LATENCY = 3;

    function automatic bit width_ok(input int w);
        return (w == 8) || (w == 16) || (w == 32);
    endfunction

    // One 4x4 block per nibble pair of the two operands.
    function automatic int pp_count(input int w);
        return (w / 4) * (w / 4);
    endfunction

endpackage

// File: rtl/vedic_4x4.sv
// 4x4 Urdhva-Tiryagbhyam (vertical and crosswise) unsigned multiplier, combinational.
module vedic_4x4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    function automatic logic [7:0] b8(input logic x);
        return {7'b0, x};
    endfunction

    logic [7:0] c0, c1, c2, c3, c4, c5, c6;

    // Column k collects every bit product a[i]*b[j] with i+j == k.
    assign c0 = b8(a_i[0] & b_i[0]);
    assign c1 = b8(a_i[1] & b_i[0]) + b8(a_i[0] & b_i[1]);
    assign c2 = b8(a_i[2] & b_i[0]) + b8(a_i[1] & b_i[1]) + b8(a_i[0] & b_i[2]);
    assign c3 = b8(a_i[3] & b_i[0]) + b8(a_i[2] & b_i[1]) + b8(a_i[1] & b_i[2])
              + b8(a_i[0] & b_i[3]);
    assign c4 = b8(a_i[3] & b_i[1]) + b8(a_i[2] & b_i[2]) + b8(a_i[1] & b_i[3]);
    assign c5 = b8(a_i[3] & b_i[2]) + b8(a_i[2] & b_i[3]);
    assign c6 = b8(a_i[3] & b_i[3]);

    assign p_o = c0 + (c1 << 1) + (c2 << 2) + (c3 << 3) + (c4 << 4) + (c5 << 5) + (c6 << 6);

endmodule

// File: rtl/vedic_mul_pipe.sv
// Three-stage pipelined sign-magnitude multiplier built from 4x4 Vedic blocks,
// with a single valid/ready advance enable shared by every stage.
module vedic_mul_pipe
    import vedic_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               busy
);

    localparam int NB  = WIDTH / 4;
    localparam int NPP = pp_count(WIDTH);
    localparam int PW  = 2 * WIDTH;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("vedic_mul_pipe: WIDTH must be 8, 16 or 32");
    end

    logic                  en;
    logic [LATENCY:1]      vld_pipe_q;
    logic                  sgn_mode;
    logic [WIDTH-1:0]      mag_a_d, mag_b_d, mag_a_q, mag_b_q;
    logic                  neg_d, neg1_q, neg2_q;
    logic [NPP-1:0][7:0]   pp_d, pp_q;
    logic [PW-1:0]         sum_d, prod_d, out_p_q;

    assign en        = !vld_pipe_q[LATENCY] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_pipe_q[LATENCY];
    assign out_p     = out_p_q;
    assign busy      = |vld_pipe_q;

    // |x| in WIDTH bits: the most-negative operand maps to 2^(WIDTH-1) unchanged.
    assign sgn_mode = SIGNED_EN && in_signed;
    assign mag_a_d  = (sgn_mode && in_a[WIDTH-1]) ? -in_a : in_a;
    assign mag_b_d  = (sgn_mode && in_b[WIDTH-1]) ? -in_b : in_b;
    assign neg_d    = sgn_mode && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);

    for (genvar i = 0; i < NB; i++) begin : g_a
        for (genvar j = 0; j < NB; j++) begin : g_b
            vedic_4x4 u_pp (
                .a_i (mag_a_q[4*i +: 4]),
                .b_i (mag_b_q[4*j +: 4]),
                .p_o (pp_d[i*NB + j])
            );
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NB; i++) begin
            for (int j = 0; j < NB; j++) begin
                sum_d = sum_d + (PW'(pp_q[i*NB + j]) << (4 * (i + j)));
            end
        end
        prod_d = neg2_q ? -sum_d : sum_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            neg1_q     <= 1'b0;
            pp_q       <= '0;
            neg2_q     <= 1'b0;
            out_p_q    <= '0;
        end else if (en) begin
            vld_pipe_q <= {vld_pipe_q[LATENCY-1:1], in_valid};
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            neg1_q     <= neg_d;
            pp_q       <= pp_d;
            neg2_q     <= neg1_q;
            // Bubbles leave the last delivered product on out_p.
            if (vld_pipe_q[LATENCY-1]) out_p_q <= prod_d;
        end
    end

endmodule
